// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam int unsigned       DEF_MAX_D_BURST = 4;
  localparam int unsigned       DEF_TIMEOUT     = 255;
  localparam logic [DATA_W-1:0] DEF_ERR_RDATA   = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  // Payload driven onto the memory port for one granted transaction.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mem_cmd_t;

  function automatic arb_state_e busy_state(input req_id_e id);
    return (id == REQ_I) ? BUSY_I : BUSY_D;
  endfunction

  function automatic arb_state_e done_state(input req_id_e id);
    return (id == REQ_I) ? DONE_I : DONE_D;
  endfunction

  // Fetches are full-word reads.
  function automatic mem_cmd_t fetch_cmd(input logic [ADDR_W-1:0] addr);
    mem_cmd_t cmd;
    cmd.we    = 1'b0;
    cmd.addr  = addr;
    cmd.wdata = '0;
    cmd.be    = '1;
    return cmd;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle counter that flags a memory transaction as hung after TIMEOUT cycles.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned          CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(TIMEOUT - 1);
  localparam bit                   ENABLED  = (TIMEOUT != 0);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Expiry only counts a cycle without m_ack, so a late ack still wins.
  assign expire_c = ENABLED && en && (cnt_q == LAST_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch (read-only) and data (read/write)
// requesters: data priority with bounded fetch starvation, plus a hang watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned       MAX_D_BURST = DEF_MAX_D_BURST,
  parameter int unsigned       TIMEOUT     = DEF_TIMEOUT,
  parameter logic [DATA_W-1:0] ERR_RDATA   = DEF_ERR_RDATA
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_be,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,

  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [BE_W-1:0]   m_be,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,

  output logic              bus_err
);

  localparam int unsigned        BURST_W   = (MAX_D_BURST > 0) ? $clog2(MAX_D_BURST + 1) : 1;
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_D_BURST);

  arb_state_e        state_q, state_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic              m_req_q, m_req_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              bus_err_q, bus_err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  mem_cmd_t          i_cmd_c, d_cmd_c;
  logic              grant_d_c;
  req_id_e           grant_id_c, owner_c;
  logic [BURST_W-1:0] burst_inc_c;
  logic [DATA_W-1:0] done_rdata_c;
  logic              wd_clr_c, wd_en_c, wd_expire_c;

  assign i_cmd_c = fetch_cmd(i_addr);
  assign d_cmd_c = '{we: d_we, addr: d_addr, wdata: d_wdata, be: d_be};

  // Data wins unless fetch has already been passed over MAX_D_BURST times.
  assign grant_d_c   = d_req && (!i_req || (burst_q < BURST_MAX));
  assign grant_id_c  = grant_d_c ? REQ_D : REQ_I;
  assign burst_inc_c = (burst_q == BURST_MAX) ? burst_q : burst_q + BURST_W'(1);

  assign owner_c      = (state_q == BUSY_I) ? REQ_I : REQ_D;
  assign done_rdata_c = m_ack ? m_rdata : ERR_RDATA;

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clr      (wd_clr_c),
    .en       (wd_en_c),
    .expire_c (wd_expire_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    cmd_d     = cmd_q;
    m_req_d   = m_req_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    bus_err_d = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    wd_clr_c  = 1'b0;
    wd_en_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_req || i_req) begin
          cmd_d    = grant_d_c ? d_cmd_c : i_cmd_c;
          m_req_d  = 1'b1;
          state_d  = busy_state(grant_id_c);
          wd_clr_c = 1'b1;
          burst_d  = (grant_d_c && i_req) ? burst_inc_c : '0;
        end
      end

      BUSY_I, BUSY_D: begin
        wd_en_c = !m_ack;
        if (m_ack || wd_expire_c) begin
          m_req_d   = 1'b0;
          bus_err_d = !m_ack;
          state_d   = done_state(owner_c);
          if (owner_c == REQ_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = done_rdata_c;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = done_rdata_c;
          end
        end
      end

      DONE_I, DONE_D: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      burst_q   <= '0;
      cmd_q     <= '0;
      m_req_q   <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      bus_err_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      cmd_q     <= cmd_d;
      m_req_q   <= m_req_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      bus_err_q <= bus_err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = cmd_q.we;
  assign m_addr  = cmd_q.addr;
  assign m_wdata = cmd_q.wdata;
  assign m_be    = cmd_q.be;
  assign i_ack   = i_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_ack   = d_ack_q;
  assign d_rdata = d_rdata_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner
// sequences, and randomized traffic against a cycle-schedule reference model.
module tb_mem_port_arbiter;

  localparam int unsigned MAXB = 4;
  localparam int unsigned TO   = 8;
  localparam logic [31:0] ERRD = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_ack;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ack;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        m_req, m_we, m_ack;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MAX_D_BURST (MAXB),
    .TIMEOUT     (TO),
    .ERR_RDATA   (ERRD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_ack   (i_ack),
    .i_rdata (i_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_be    (d_be),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_be    (m_be),
    .m_ack   (m_ack),
    .m_rdata (m_rdata),
    .bus_err (bus_err)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit grant_q[$];

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
    logic        give_ack;
    logic [31:0] mdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 6;
  vec_t vt[NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] flags();
    return 64'({m_req, i_ack, d_ack, bus_err});
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_m_cmd"}, {27'h0, m_we, m_be, m_addr}, 64'h0);
    chk({tag, "_m_wdata"}, 64'(m_wdata), 64'h0);
    chk({tag, "_flags"}, flags(), 64'h0);
    chk({tag, "_i_rdata"}, 64'(i_rdata), 64'h0);
    chk({tag, "_d_rdata"}, 64'(d_rdata), 64'h0);
  endtask

  // One isolated transaction; lat = busy cycles before m_ack is driven.
  task automatic run_vec(input vec_t v, input int idx);
    logic [63:0] exp_cmd;
    string       t;
    t = $sformatf("v%0d", idx);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
      exp_cmd = {27'h0, v.we, v.be, v.addr};
    end else begin
      i_req = 1'b1; i_addr = v.addr;
      exp_cmd = {27'h0, 1'b0, 4'hF, v.addr};
    end
    tick();
    chk({t, "_m_req_rise"}, 64'(m_req), 64'd1);
    chk({t, "_m_cmd"}, {27'h0, m_we, m_be, m_addr}, exp_cmd);
    if (v.is_d) chk({t, "_m_wdata"}, 64'(m_wdata), 64'(v.wdata));
    for (int c = 0; c < v.lat; c++) begin
      tick();
      chk({t, "_busy_hold"}, flags(), 64'b1000);
    end
    if (v.give_ack) begin
      m_ack = 1'b1; m_rdata = v.mdata;
    end
    tick();
    m_ack = 1'b0; m_rdata = $urandom();
    chk({t, "_done_flags"}, flags(), 64'({1'b0, !v.is_d, v.is_d, v.exp_err}));
    chk({t, "_rdata"}, 64'(v.is_d ? d_rdata : i_rdata), 64'(v.exp_rdata));
    i_req = 1'b0; d_req = 1'b0;
    tick();
    chk({t, "_idle_flags"}, flags(), 64'h0);
  endtask

  // Reference model: each grant fixes a whole timeline by cycle arithmetic
  // (m_req over [g+1, g+1+L], ack at g+2+L, idle again from g+3+L).
  task automatic run_model(input int ncyc, input bit contend);
    int          idle_at = 0, g = -100, lat = 0, leff = 0, burst = 0;
    bit          tmo = 1'b0, who_d = 1'b0, ipend = 1'b0, dpend = 1'b0;
    bit          quiet, ack_now, in_busy;
    logic [63:0] exp_cmd = '0;
    logic [31:0] exp_wdata = '0, mdat = '0;
    i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
    for (int k = 0; k < ncyc + 30; k++) begin
      ack_now = (k == g + 2 + leff);
      in_busy = (k >= g + 1) && (k <= g + 1 + leff);
      chk("mdl_m_req", 64'(m_req), 64'(in_busy));
      if (in_busy) begin
        chk("mdl_m_cmd", {27'h0, m_we, m_be, m_addr}, exp_cmd);
        if (who_d) chk("mdl_m_wdata", 64'(m_wdata), 64'(exp_wdata));
        if (k == g + 1 && contend) grant_q.push_back(m_addr[28]);
      end
      chk("mdl_acks", 64'({i_ack, d_ack, bus_err}),
          64'({ack_now && !who_d, ack_now && who_d, ack_now && tmo}));
      if (ack_now)
        chk("mdl_rdata", 64'(who_d ? d_rdata : i_rdata), 64'(tmo ? ERRD : mdat));

      if (ack_now) begin
        if (who_d) dpend = 1'b0;
        else       ipend = 1'b0;
      end
      if (k < ncyc) begin
        if (!ipend && (contend || $urandom_range(0, 99) < 30)) begin
          ipend  = 1'b1;
          i_addr = 32'h0040_0000 | ($urandom() & 32'h0000_FFFC);
        end
        if (!dpend && (contend || $urandom_range(0, 99) < 30)) begin
          dpend   = 1'b1;
          d_we    = 1'($urandom_range(0, 1));
          d_addr  = 32'h1000_0000 | ($urandom() & 32'h00FF_FFFC);
          d_wdata = $urandom();
          d_be    = 4'($urandom());
        end
      end
      i_req = ipend;
      d_req = dpend;

      quiet = (k >= idle_at) || ack_now;
      if (k >= idle_at && (ipend || dpend)) begin
        who_d   = dpend && (!ipend || burst < int'(MAXB));
        burst   = (who_d && ipend) ? ((burst < int'(MAXB)) ? burst + 1 : burst) : 0;
        g       = k;
        lat     = contend ? 0 : $urandom_range(0, 9);
        tmo     = (lat >= 8);
        leff    = tmo ? 7 : lat;
        mdat    = $urandom();
        idle_at = g + 3 + leff;
        exp_cmd = who_d ? {27'h0, d_we, d_be, d_addr} : {27'h0, 1'b0, 4'hF, i_addr};
        exp_wdata = d_wdata;
      end

      m_ack   = 1'b0;
      m_rdata = $urandom();
      if (!tmo && k == g + 1 + lat) begin
        m_ack = 1'b1; m_rdata = mdat;
      end else if (quiet && $urandom_range(0, 99) < 15) begin
        m_ack = 1'b1;
      end
      tick();
    end
    m_ack = 1'b0;
  endtask

  initial begin
    bit exp_pat[10];
    exp_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    vt[0] = '{1'b0, 1'b0, 32'h0040_0000, 32'h0, 4'h0, 2, 1'b1, 32'h2408_0005, 32'h2408_0005, 1'b0};
    vt[1] = '{1'b1, 1'b1, 32'h1000_0010, 32'hCAFE_F00D, 4'b0011, 1, 1'b1, 32'h1111_2222, 32'h1111_2222, 1'b0};
    vt[2] = '{1'b1, 1'b0, 32'h1000_0020, 32'h0, 4'hF, 7, 1'b0, 32'h0, ERRD, 1'b1};
    vt[3] = '{1'b1, 1'b0, 32'h1000_0024, 32'h0, 4'hF, 0, 1'b1, 32'h5555_AAAA, 32'h5555_AAAA, 1'b0};
    vt[4] = '{1'b1, 1'b0, 32'h1000_0028, 32'h0, 4'hC, 7, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0};
    vt[5] = '{1'b0, 1'b0, 32'h0040_0004, 32'h0, 4'h0, 3, 1'b1, 32'h8C09_0000, 32'h8C09_0000, 1'b0};

    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    m_ack = 1'b0; m_rdata = '0;
    tick();
    tick();
    check_reset_vals("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) run_vec(vt[i], i);

    // Spurious m_ack while idle must not produce any completion.
    m_ack = 1'b1; m_rdata = 32'hFFFF_0000;
    tick();
    chk("spurious_c1", flags(), 64'h0);
    tick();
    m_ack = 1'b0;
    chk("spurious_c2", flags(), 64'h0);
    tick();
    chk("spurious_c3", flags(), 64'h0);

    // Reset while a data read is outstanding.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000_0040; d_be = 4'hF;
    tick();
    chk("mid_busy_m_req", 64'(m_req), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; d_req = 1'b0;
    check_reset_vals("mid_reset");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_reset_quiet", flags(), 64'h0);
    end
    run_vec(vt[0], 100);

    // Both requesters saturated: fetch must win every fifth grant.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_model(120, 1'b1);
    chk("contend_count_ok", 64'(grant_q.size() >= 10), 64'd1);
    if (grant_q.size() >= 10)
      for (int i = 0; i < 10; i++)
        chk($sformatf("contend_grant%0d", i), 64'(grant_q[i]), 64'(exp_pat[i]));

    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_model(3000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
